// File: rtl/acc_diff_pkg.sv
// Shared constants and state encoding for the accumulator differencer (acc_diff).
package acc_diff_pkg;

  localparam int AW_DEF = 16;
  localparam int XW_DEF = 10;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/acc_diff_fsm.sv
// State register and accept/error/clear decode for acc_diff.
// ACC_DIFF_ZERO_PRIME_EN makes the first sample after reset/clr produce an increment against prev=0.
module acc_diff_fsm
  import acc_diff_pkg::*;
(
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic a_vld,
  input  logic in_range,
  output logic prev_ld,
  output logic prev_clr,
  output logic emit,
  output logic err
);

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (!rst_b)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    prev_ld   = 1'b0;
    prev_clr  = 1'b0;
    emit      = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
      prev_clr  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (a_vld) begin
`ifdef ACC_DIFF_ZERO_PRIME_EN
            // prev is known to be zero here, so d is simply the sample itself
            if (in_range) begin
              prev_ld   = 1'b1;
              emit      = 1'b1;
              state_nxt = RUN;
            end else begin
              state_nxt = ERR;
            end
`else
            prev_ld   = 1'b1;
            state_nxt = RUN;
`endif
          end
        end
        RUN: begin
          if (a_vld) begin
            if (in_range) begin
              prev_ld = 1'b1;
              emit    = 1'b1;
            end else begin
              state_nxt = ERR;
            end
          end
        end
        ERR:     state_nxt = ERR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign err = (state == ERR);

endmodule

// File: rtl/rgst.sv
// Generic load/clear register; clr takes priority over ld, synchronous active-low reset.
module rgst #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         ld,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_b)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (ld)
      q <= d;
  end

endmodule

// File: rtl/acc_diff.sv
// Recovers XW-bit increments from a stream of AW-bit accumulator samples, x[n] = a[n] - a[n-1].
// Optional macro ACC_DIFF_ZERO_PRIME_EN: first sample is differenced against an implicit zero.
module acc_diff
  import acc_diff_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int XW = XW_DEF
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          a_vld,
  input  logic [AW-1:0] a,
  input  logic          clr,
  output logic          x_vld,
  output logic [XW-1:0] x,
  output logic          err,
  output logic [15:0]   cnt
);

  logic [AW-1:0] prev;
  logic [AW-1:0] d;
  logic          in_range;
  logic          prev_ld;
  logic          prev_clr;
  logic          emit;

  // Modulo-2^AW subtraction makes accumulator wrap-around a legal step
  assign d        = a - prev;
  assign in_range = ~|d[AW-1:XW];

  acc_diff_fsm u_fsm (
    .clk      (clk),
    .rst_b    (rst_b),
    .clr      (clr),
    .a_vld    (a_vld),
    .in_range (in_range),
    .prev_ld  (prev_ld),
    .prev_clr (prev_clr),
    .emit     (emit),
    .err      (err)
  );

  rgst #(.W(AW)) u_prev (
    .clk   (clk),
    .rst_b (rst_b),
    .ld    (prev_ld),
    .clr   (prev_clr),
    .d     (a),
    .q     (prev)
  );

  rgst #(.W(XW)) u_x (
    .clk   (clk),
    .rst_b (rst_b),
    .ld    (emit),
    .clr   (1'b0),
    .d     (d[XW-1:0]),
    .q     (x)
  );

  always_ff @(posedge clk) begin
    if (!rst_b)
      x_vld <= 1'b0;
    else
      x_vld <= emit;
  end

  always_ff @(posedge clk) begin
    if (!rst_b)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (emit && (cnt != CNT_MAX))
      cnt <= cnt + 16'd1;
  end

endmodule
